// File: rtl/ula_pkg.sv
// Shared definitions for the ULA sequencer:
// opcode values and controller state encoding.
package ula_pkg;

  localparam logic [2:0] OP_SOMA   = 3'b000;
  localparam logic [2:0] OP_SUB    = 3'b001;
  localparam logic [2:0] OP_AND    = 3'b010;
  localparam logic [2:0] OP_OR     = 3'b011;
  localparam logic [2:0] OP_XOR    = 3'b100;
  localparam logic [2:0] OP_MUL    = 3'b101;
  localparam logic [2:0] OP_DIV    = 3'b110;
  localparam logic [2:0] OP_ILEGAL = 3'b111;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/ula_controlador.sv
// Command sequencer for the 4-bit ULA: registers operands,
// waits the settle window, captures and holds the result.
module ula_controlador
  import ula_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_a,
  input  logic [3:0] cmd_b,
  input  logic       cmd_cin,
  input  logic [2:0] cmd_op,
  input  logic       cmd_acc,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] res_data,
  output logic       res_cout,
  output logic       res_ov,
  output logic       res_z,
  output logic       res_err,
  output logic [3:0] ula_a,
  output logic [3:0] ula_b,
  output logic       ula_cin,
  output logic [2:0] ula_op,
  input  logic [7:0] ula_result,
  input  logic       ula_cout,
  input  logic       ula_ov,
  input  logic       ula_z,
  input  logic       ula_err,
  output logic       busy,
  output logic [7:0] op_count
);

  localparam logic [CNT_W-1:0] CNT_INIT =
    CNT_W'(SETTLE_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       acc_q, acc_d;
  logic [7:0]       cnt_ops_q, cnt_ops_d;
  logic             rdy_q, rdy_d;
  logic             vld_q, vld_d;
  logic             busy_q, busy_d;
  logic [3:0]       a_q, a_d;
  logic [3:0]       b_q, b_d;
  logic             cin_q, cin_d;
  logic [2:0]       op_q, op_d;
  logic [7:0]       data_q, data_d;
  logic             cout_q, cout_d;
  logic             ov_q, ov_d;
  logic             z_q, z_d;
  logic             err_q, err_d;

  // Next-state and datapath-register logic for the sequencer
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    cnt_ops_d = cnt_ops_q;
    rdy_d     = rdy_q;
    vld_d     = vld_q;
    busy_d    = busy_q;
    a_d       = a_q;
    b_d       = b_q;
    cin_d     = cin_q;
    op_d      = op_q;
    data_d    = data_q;
    cout_d    = cout_q;
    ov_d      = ov_q;
    z_d       = z_q;
    err_d     = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          a_d     = cmd_acc ? acc_q[3:0] : cmd_a;
          b_d     = cmd_b;
          cin_d   = cmd_cin;
          op_d    = cmd_op;
          cnt_d   = CNT_INIT;
          state_d = ST_EXEC;
          rdy_d   = 1'b0;
          busy_d  = 1'b1;
        end
      end
      ST_EXEC: begin
        if (cnt_q == '0) begin
          if (op_q == OP_ILEGAL) begin
            data_d = 8'h00;
            cout_d = 1'b0;
            ov_d   = 1'b0;
            z_d    = 1'b1;
          end else begin
            data_d = ula_result;
            cout_d = ula_cout;
            ov_d   = ula_ov;
            z_d    = ula_z;
          end
          err_d   = ((op_q == OP_DIV) & ula_err)
                  | (op_q == OP_ILEGAL);
          vld_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DONE: begin
        if (res_ready) begin
          vld_d     = 1'b0;
          rdy_d     = 1'b1;
          busy_d    = 1'b0;
          cnt_ops_d = cnt_ops_q + 1'b1;
          if (!err_q) acc_d = data_q;
          state_d   = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        rdy_d   = 1'b1;
        vld_d   = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and registered-output flops with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      cnt_ops_q <= '0;
      rdy_q     <= 1'b1;
      vld_q     <= 1'b0;
      busy_q    <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      cin_q     <= 1'b0;
      op_q      <= '0;
      data_q    <= '0;
      cout_q    <= 1'b0;
      ov_q      <= 1'b0;
      z_q       <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      cnt_ops_q <= cnt_ops_d;
      rdy_q     <= rdy_d;
      vld_q     <= vld_d;
      busy_q    <= busy_d;
      a_q       <= a_d;
      b_q       <= b_d;
      cin_q     <= cin_d;
      op_q      <= op_d;
      data_q    <= data_d;
      cout_q    <= cout_d;
      ov_q      <= ov_d;
      z_q       <= z_d;
      err_q     <= err_d;
    end
  end

  assign cmd_ready = rdy_q;
  assign res_valid = vld_q;
  assign busy      = busy_q;
  assign op_count  = cnt_ops_q;
  assign ula_a     = a_q;
  assign ula_b     = b_q;
  assign ula_cin   = cin_q;
  assign ula_op    = op_q;
  assign res_data  = data_q;
  assign res_cout  = cout_q;
  assign res_ov    = ov_q;
  assign res_z     = z_q;
  assign res_err   = err_q;

endmodule

// File: tb/tb_ula_controlador.sv
// Directed bench for ula_controlador with a small
// behavioural ULA model driving the result inputs.
module tb_ula_controlador;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready;
  logic [3:0] cmd_a, cmd_b;
  logic       cmd_cin, cmd_acc;
  logic [2:0] cmd_op;
  logic       res_valid, res_ready;
  logic [7:0] res_data;
  logic       res_cout, res_ov, res_z, res_err;
  logic [3:0] ula_a, ula_b;
  logic       ula_cin;
  logic [2:0] ula_op;
  logic [7:0] ula_result;
  logic       ula_cout, ula_ov, ula_z, ula_err;
  logic       busy;
  logic [7:0] op_count;
  logic       force_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ula_controlador #(.SETTLE_CYCLES(1)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_cin(cmd_cin),
    .cmd_op(cmd_op), .cmd_acc(cmd_acc),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_cout(res_cout),
    .res_ov(res_ov), .res_z(res_z), .res_err(res_err),
    .ula_a(ula_a), .ula_b(ula_b), .ula_cin(ula_cin),
    .ula_op(ula_op), .ula_result(ula_result),
    .ula_cout(ula_cout), .ula_ov(ula_ov), .ula_z(ula_z),
    .ula_err(ula_err), .busy(busy), .op_count(op_count)
  );

  // Behavioural ULA
  always_comb begin
    logic [4:0] s;
    s = 5'd0;
    ula_result = 8'd0;
    ula_cout = 1'b0;
    ula_ov = 1'b0;
    ula_err = 1'b0;
    case (ula_op)
      3'b000: begin
        s = {1'b0, ula_a} + {1'b0, ula_b} + {4'd0, ula_cin};
        ula_result = {4'd0, s[3:0]};
        ula_cout = s[4];
        ula_ov = (ula_a[3] == ula_b[3]) && (s[3] != ula_a[3]);
      end
      3'b001: begin
        s = {1'b0, ula_a} - {1'b0, ula_b} - {4'd0, ula_cin};
        ula_result = {4'd0, s[3:0]};
        ula_cout = s[4];
        ula_ov = (ula_a[3] != ula_b[3]) && (s[3] != ula_a[3]);
      end
      3'b010: ula_result = {4'd0, ula_a & ula_b};
      3'b011: ula_result = {4'd0, ula_a | ula_b};
      3'b100: ula_result = {4'd0, ula_a ^ ula_b};
      3'b101: ula_result = {4'd0, ula_a} * {4'd0, ula_b};
      3'b110: begin
        if (ula_b == 4'd0) ula_err = 1'b1;
        else ula_result = {4'd0, ula_a / ula_b};
      end
      default: ula_result = 8'd0;
    endcase
    ula_z = (ula_result == 8'd0);
    ula_err = ula_err | force_err;
  end

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one command; returns at #1 after the accepting edge
  task automatic issue(input logic [3:0] a,
                       input logic [3:0] b,
                       input logic cin,
                       input logic [2:0] op,
                       input logic acc);
    int n;
    n = 0;
    while (!cmd_ready && n < 20) begin
      step();
      n++;
    end
    if (!cmd_ready) chk("ready_timeout", 8'd0, 8'd1);
    cmd_a = a;
    cmd_b = b;
    cmd_cin = cin;
    cmd_op = op;
    cmd_acc = acc;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_res();
    int n;
    n = 0;
    while (!res_valid && n < 20) begin
      step();
      n++;
    end
    if (!res_valid) chk("res_timeout", 8'd0, 8'd1);
  endtask

  task automatic handshake();
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
  endtask

  initial begin
    logic [7:0] held;
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_a = '0;
    cmd_b = '0;
    cmd_cin = 1'b0;
    cmd_op = '0;
    cmd_acc = 1'b0;
    res_ready = 1'b0;
    force_err = 1'b0;
    step();
    step();
    rst = 1'b0;
    chk("rst_ready", {7'd0, cmd_ready}, 8'd1);
    chk("rst_valid", {7'd0, res_valid}, 8'd0);
    chk("rst_count", op_count, 8'd0);
    chk("rst_ula_a", {4'd0, ula_a}, 8'd0);
    chk("rst_ula_op", {5'd0, ula_op}, 8'd0);
    chk("rst_busy", {7'd0, busy}, 8'd0);

    // Add 3+4
    issue(4'd3, 4'd4, 1'b0, 3'b000, 1'b0);
    chk("add_ula_a", {4'd0, ula_a}, 8'd3);
    chk("add_busy", {7'd0, busy}, 8'd1);
    chk("add_rdy_lo", {7'd0, cmd_ready}, 8'd0);
    chk("add_no_vld", {7'd0, res_valid}, 8'd0);
    step();
    chk("add_vld", {7'd0, res_valid}, 8'd1);
    chk("add_data", res_data, 8'h07);
    chk("add_z", {7'd0, res_z}, 8'd0);
    chk("add_err", {7'd0, res_err}, 8'd0);
    handshake();
    chk("add_cnt", op_count, 8'd1);
    chk("add_vld_lo", {7'd0, res_valid}, 8'd0);
    chk("add_rdy", {7'd0, cmd_ready}, 8'd1);

    // Chain: acc(7) * 3
    issue(4'd0, 4'd3, 1'b0, 3'b101, 1'b1);
    chk("mul_ula_a", {4'd0, ula_a}, 8'd7);
    wait_res();
    chk("mul_data", res_data, 8'd21);
    handshake();
    chk("mul_cnt", op_count, 8'd2);

    // acc=21 -> low nibble 5, plus 1
    issue(4'hF, 4'd1, 1'b0, 3'b000, 1'b1);
    chk("lo_ula_a", {4'd0, ula_a}, 8'd5);
    wait_res();
    chk("lo_data", res_data, 8'd6);
    handshake();

    // Divide by zero: error, acc stays 6
    issue(4'd8, 4'd0, 1'b0, 3'b110, 1'b0);
    wait_res();
    chk("div_err", {7'd0, res_err}, 8'd1);
    handshake();
    chk("div_cnt", op_count, 8'd4);
    issue(4'd0, 4'd0, 1'b0, 3'b000, 1'b1);
    chk("div_acc", {4'd0, ula_a}, 8'd6);
    wait_res();
    chk("acc_data", res_data, 8'd6);
    handshake();

    // ULA err on add is ignored
    force_err = 1'b1;
    issue(4'd1, 4'd1, 1'b0, 3'b000, 1'b0);
    wait_res();
    force_err = 1'b0;
    chk("fe_err", {7'd0, res_err}, 8'd0);
    chk("fe_data", res_data, 8'd2);
    handshake();

    // Illegal opcode, consumer stalls, stray command pulse
    issue(4'd2, 4'd3, 1'b1, 3'b111, 1'b0);
    chk("il_ula_op", {5'd0, ula_op}, 8'd7);
    wait_res();
    chk("il_err", {7'd0, res_err}, 8'd1);
    chk("il_data", res_data, 8'd0);
    chk("il_z", {7'd0, res_z}, 8'd1);
    held = res_data;
    cmd_a = 4'd9;
    cmd_op = 3'b000;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("il_hold_vld", {7'd0, res_valid}, 8'd1);
    chk("il_hold_data", res_data, held);
    chk("il_hold_err", {7'd0, res_err}, 8'd1);
    chk("il_hold_rdy", {7'd0, cmd_ready}, 8'd0);
    chk("il_pulse_a", {4'd0, ula_a}, 8'd2);
    handshake();
    chk("il_cnt", op_count, 8'd7);
    chk("il_keep_op", {5'd0, ula_op}, 8'd7);
    step();
    chk("il_idle_vld", {7'd0, res_valid}, 8'd0);

    // Reset during EXEC
    issue(4'd1, 4'd2, 1'b0, 3'b000, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mr_busy", {7'd0, busy}, 8'd0);
    chk("mr_vld", {7'd0, res_valid}, 8'd0);
    chk("mr_rdy", {7'd0, cmd_ready}, 8'd1);
    chk("mr_cnt", op_count, 8'd0);
    step();
    chk("mr_vld2", {7'd0, res_valid}, 8'd0);

    // Wrap of op_count
    res_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      issue(4'(i), 4'd1, 1'b0, 3'b010, 1'b0);
      wait_res();
      step();
      if (i == 254) chk("wrap_255", op_count, 8'd255);
    end
    res_ready = 1'b0;
    chk("wrap_0", op_count, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
